// File: rtl/time_set_ctrl.sv
// Time-set controller: button-driven editor for an MM:SS BCD time value.
// Buttons are edge-detected, then a three-state FSM (IDLE/EDIT/COMMIT)
// captures the running time, lets the user move a one-hot cursor and
// inc/dec the digit under it, and strobes load_pulse to commit the result.
// An idle edit is abandoned after TIMEOUT_CYCLES cycles without a press.
module time_set_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_btn,
  input  logic       move_right_btn,
  input  logic       move_left_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic [2:0] cur_minutes_tens,
  input  logic [3:0] cur_minutes_ones,
  input  logic [2:0] cur_seconds_tens,
  input  logic [3:0] cur_seconds_ones,
  output logic       set_status,
  output logic [3:0] set_id,
  output logic [3:0] set_num,
  output logic [2:0] load_minutes_tens,
  output logic [3:0] load_minutes_ones,
  output logic [2:0] load_seconds_tens,
  output logic [3:0] load_seconds_ones,
  output logic       load_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Button vector bit positions.
  localparam int B_SET   = 4;
  localparam int B_RIGHT = 3;
  localparam int B_LEFT  = 2;
  localparam int B_INC   = 1;
  localparam int B_DEC   = 0;

  // Digit index: 0 = minutes tens, 1 = minutes ones, 2 = seconds tens,
  // 3 = seconds ones. Odd indices are ones digits (0..9), even are tens (0..5).
  function automatic logic [3:0] digit_max(input logic [1:0] idx);
    return idx[0] ? 4'd9 : 4'd5;
  endfunction

  logic [4:0]       btn;
  logic [4:0]       btn_prev;
  logic [4:0]       ev;

  state_t           state, state_n;
  logic [1:0]       cursor, cursor_n;
  logic [3:0][3:0]  dig, dig_n;
  logic [31:0]      tmo_cnt, tmo_cnt_n;
  logic             set_status_n;
  logic [3:0]       set_id_n;
  logic [3:0]       set_num_n;
  logic             load_pulse_n;
  logic             ev_edit;
  logic [3:0]       cur_digit;

  assign btn = {set_btn, move_right_btn, move_left_btn, inc_btn, dec_btn};

  // Edge detection: register previous level and the one-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Previous levels reset high so a button held through reset is not an event.
      btn_prev <= '1;
      ev       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      btn_prev <= btn;
      ev       <= btn & ~btn_prev;
    end
  end

  assign ev_edit   = |ev[B_RIGHT:B_DEC];
  assign cur_digit = dig[cursor];

  // Next-state, edit-register and registered-output computation.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_n   = state;
    cursor_n  = cursor;
    dig_n     = dig;
    tmo_cnt_n = tmo_cnt;

    unique case (state)
      IDLE: begin
        if (ev[B_SET]) begin
          state_n   = EDIT;
          cursor_n  = 2'd0;
          tmo_cnt_n = '0;
          dig_n[0]  = {1'b0, cur_minutes_tens};
          dig_n[1]  = cur_minutes_ones;
          dig_n[2]  = {1'b0, cur_seconds_tens};
          dig_n[3]  = cur_seconds_ones;
        end
      end

      EDIT: begin
        if (ev[B_SET]) begin
          state_n   = COMMIT;
          tmo_cnt_n = '0;
        end else if (ev_edit) begin
          tmo_cnt_n = '0;
          // Inc/dec act on the digit under the pre-move cursor.
          if (ev[B_INC] && !ev[B_DEC]) begin
            dig_n[cursor] = (cur_digit == digit_max(cursor)) ? 4'd0 : cur_digit + 4'd1;
          end else if (ev[B_DEC] && !ev[B_INC]) begin
            dig_n[cursor] = (cur_digit == 4'd0) ? digit_max(cursor) : cur_digit - 4'd1;
          end
          // Two-bit cursor wraps naturally at both ends.
          if (ev[B_RIGHT] && !ev[B_LEFT]) begin
            cursor_n = cursor + 2'd1;
          end else if (ev[B_LEFT] && !ev[B_RIGHT]) begin
            cursor_n = cursor - 2'd1;
          end
        end else if (tmo_cnt == TIMEOUT_CYCLES - 32'd1) begin
          // Abandon the edit; entered digits stay in the edit registers.
          state_n   = IDLE;
          tmo_cnt_n = '0;
        end else begin
          tmo_cnt_n = tmo_cnt + 32'd1;
        end
      end

      COMMIT: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    set_status_n = (state_n != IDLE);
    load_pulse_n = (state_n == COMMIT);
    set_id_n     = set_status_n ? (4'b1000 >> cursor_n) : 4'b0000;
    set_num_n    = set_status_n ? dig_n[cursor_n] : 4'd0;
  end

  // State, edit registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cursor     <= 2'd0;
      // NOTE: the edit digits are a handful of flops, not a RAM, so they are
      // reset like any other register to give load_* a defined value.
      dig        <= '0;
      tmo_cnt    <= '0;
      set_status <= 1'b0;
      set_id     <= 4'b0000;
      set_num    <= 4'd0;
      load_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      cursor     <= cursor_n;
      dig        <= dig_n;
      tmo_cnt    <= tmo_cnt_n;
      set_status <= set_status_n;
      set_id     <= set_id_n;
      set_num    <= set_num_n;
      load_pulse <= load_pulse_n;
    end
  end

  assign load_minutes_tens = dig[0][2:0];
  assign load_minutes_ones = dig[1];
  assign load_seconds_tens = dig[2][2:0];
  assign load_seconds_ones = dig[3];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed testbench for time_set_ctrl with a short edit timeout.
module tb_time_set_ctrl;

  localparam logic [31:0] TMO = 32'd100;

  localparam logic [4:0] SET   = 5'b10000;
  localparam logic [4:0] RIGHT = 5'b01000;
  localparam logic [4:0] LEFT  = 5'b00100;
  localparam logic [4:0] INC   = 5'b00010;
  localparam logic [4:0] DEC   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_btn, move_right_btn, move_left_btn, inc_btn, dec_btn;
  logic [2:0] cur_minutes_tens, cur_seconds_tens;
  logic [3:0] cur_minutes_ones, cur_seconds_ones;
  logic       set_status;
  logic [3:0] set_id, set_num;
  logic [2:0] load_minutes_tens, load_seconds_tens;
  logic [3:0] load_minutes_ones, load_seconds_ones;
  logic       load_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  int p0;

  time_set_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .set_btn           (set_btn),
    .move_right_btn    (move_right_btn),
    .move_left_btn     (move_left_btn),
    .inc_btn           (inc_btn),
    .dec_btn           (dec_btn),
    .cur_minutes_tens  (cur_minutes_tens),
    .cur_minutes_ones  (cur_minutes_ones),
    .cur_seconds_tens  (cur_seconds_tens),
    .cur_seconds_ones  (cur_seconds_ones),
    .set_status        (set_status),
    .set_id            (set_id),
    .set_num           (set_num),
    .load_minutes_tens (load_minutes_tens),
    .load_minutes_ones (load_minutes_ones),
    .load_seconds_tens (load_seconds_tens),
    .load_seconds_ones (load_seconds_ones),
    .load_pulse        (load_pulse)
  );

  always #5 clk = ~clk;

  // Count load_pulse cycles, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (load_pulse) pulse_cnt++;
  end

  // Watchdog so the run always ends.
  initial begin
    #1ms;
    $display("FAIL watchdog: sim time exceeded, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    {set_btn, move_right_btn, move_left_btn, inc_btn, dec_btn} = m;
  endtask

  // Press for one cycle; returns at the negedge where the 2-cycle result is visible.
  task automatic press(input logic [4:0] m);
    @(negedge clk);
    set_btns(m);
    @(negedge clk);
    set_btns(5'b0);
    @(negedge clk);
  endtask

  task automatic set_cur(input logic [2:0] mt, input logic [3:0] mo,
                         input logic [2:0] st, input logic [3:0] so);
    cur_minutes_tens = mt;
    cur_minutes_ones = mo;
    cur_seconds_tens = st;
    cur_seconds_ones = so;
  endtask

  task automatic check_load(input string tag, input logic [3:0] mt, input logic [3:0] mo,
                            input logic [3:0] st, input logic [3:0] so);
    check({tag, "_mt"}, {29'd0, load_minutes_tens}, {28'd0, mt});
    check({tag, "_mo"}, {28'd0, load_minutes_ones}, {28'd0, mo});
    check({tag, "_st"}, {29'd0, load_seconds_tens}, {28'd0, st});
    check({tag, "_so"}, {28'd0, load_seconds_ones}, {28'd0, so});
  endtask

  initial begin
    logic [3:0] inc_exp [5];
    logic [3:0] right_exp [4];
    inc_exp   = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    right_exp = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};

    // Reset with set held high through release.
    rst_n = 1'b0;
    set_btns(SET);
    set_cur(3'd1, 4'd2, 3'd3, 4'd4);
    repeat (3) @(negedge clk);
    check("rst_status", set_status, 0);
    check("rst_id", set_id, 0);
    check("rst_num", set_num, 0);
    check("rst_pulse", load_pulse, 0);
    check_load("rst_load", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("held_set_no_edit", set_status, 0);
    set_btns(5'b0);
    repeat (2) @(negedge clk);

    // Enter edit at 12:34, inc minutes tens five times (tens wrap 5->0).
    press(SET);
    check("enter_status", set_status, 1);
    check("enter_id", set_id, 4'b1000);
    check("enter_num", set_num, 1);
    for (int i = 0; i < 5; i++) begin
      press(INC);
      check($sformatf("inc_%0d", i), set_num, inc_exp[i]);
    end

    // Commit 02:34.
    p0 = pulse_cnt;
    press(SET);
    check("commit_pulse", load_pulse, 1);
    check("commit_status", set_status, 1);
    check_load("commit1", 0, 2, 3, 4);
    @(negedge clk);
    check("post_commit_pulse", load_pulse, 0);
    check("post_commit_status", set_status, 0);
    check("post_commit_id", set_id, 0);
    check("post_commit_num", set_num, 0);
    check("commit1_pulses", pulse_cnt - p0, 1);

    // Inc/move events in IDLE are ignored; load holds.
    press(INC);
    press(RIGHT);
    check("idle_status", set_status, 0);
    check_load("idle_hold", 0, 2, 3, 4);

    // Enter at 00:00, cursor walk and wrap, dec wrap on ones digit.
    set_cur(3'd0, 4'd0, 3'd0, 4'd0);
    press(SET);
    check("z_enter_id", set_id, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      press(RIGHT);
      check($sformatf("right_%0d", i), set_id, right_exp[i]);
    end
    press(LEFT);
    check("left_wrap_id", set_id, 4'b0001);
    press(DEC);
    check("dec_so_wrap", set_num, 9);
    check("dec_no_borrow_st", load_seconds_tens, 0);
    press(LEFT);
    press(DEC);
    check("dec_st_wrap", set_num, 5);
    press(LEFT);
    press(DEC);
    check("dec_mo_wrap", set_num, 9);
    press(LEFT);
    check("left_to_mt", set_id, 4'b1000);
    press(DEC);
    check("dec_mt_wrap", set_num, 5);
    p0 = pulse_cnt;
    press(SET);
    check("commit2_pulse", load_pulse, 1);
    check_load("commit2", 5, 9, 5, 9);
    @(negedge clk);
    check("commit2_status_off", set_status, 0);
    check("commit2_id_off", set_id, 0);
    @(negedge clk);
    check("commit2_pulses", pulse_cnt - p0, 1);

    // Simultaneous events at 12:34.
    set_cur(3'd1, 4'd2, 3'd3, 4'd4);
    press(SET);
    press(INC | DEC);
    check("incdec_same", set_num, 1);
    press(RIGHT | INC);
    check("move_inc_id", set_id, 4'b0100);
    check("move_inc_num", set_num, 2);
    check("move_inc_mt", load_minutes_tens, 2);
    press(LEFT | RIGHT);
    check("leftright_id", set_id, 4'b0100);
    p0 = pulse_cnt;
    press(SET | INC);
    check("set_inc_pulse", load_pulse, 1);
    check_load("set_inc", 2, 2, 3, 4);
    @(negedge clk);
    check("set_inc_pulses", pulse_cnt - p0, 1);

    // Timeout with no presses: EDIT for exactly TMO cycles, no pulse.
    p0 = pulse_cnt;
    press(SET);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_still_edit", set_status, 1);
    @(negedge clk);
    check("tmo_idle", set_status, 0);
    check("tmo_id", set_id, 0);
    check("tmo_pulses", pulse_cnt - p0, 0);

    // Press midway restarts the count; entered digit is kept.
    p0 = pulse_cnt;
    press(SET);
    repeat (48) @(negedge clk);
    press(INC);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_restart_edit", set_status, 1);
    @(negedge clk);
    check("tmo_restart_idle", set_status, 0);
    check("tmo_restart_pulses", pulse_cnt - p0, 0);
    check("tmo_keep_mt", load_minutes_tens, 2);

    // Reset mid-edit aborts immediately.
    press(SET);
    press(INC);
    check("pre_rst_num", set_num, 2);
    p0 = pulse_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_status", set_status, 0);
    check("mid_rst_id", set_id, 0);
    check("mid_rst_num", set_num, 0);
    check("mid_rst_pulse", load_pulse, 0);
    check_load("mid_rst_load", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_status", set_status, 0);
    check("post_rst_pulses", pulse_cnt - p0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
